// File: rtl/nios_mul_pkg.sv
// Shared types and helpers for the Nios pipelined multiplier.
package nios_mul_pkg;

    localparam int OP_W = 2;

    // Legal result latencies: two stages, or three with an output register.
    localparam int PIPE_STAGES_MIN = 2;
    localparam int PIPE_STAGES_MAX = 3;

    typedef enum logic [OP_W-1:0] {
        MUL    = 2'b00,
        MULXSS = 2'b01,
        MULXSU = 2'b10,
        MULXUU = 2'b11
    } mul_op_e;

    // Operand A is treated as two's complement for the signed/mixed high-word ops.
    function automatic logic is_a_signed(input mul_op_e op);
        return (op == MULXSS) || (op == MULXSU);
    endfunction

    // Operand B is treated as two's complement only for signed x signed.
    function automatic logic is_b_signed(input mul_op_e op);
        return (op == MULXSS);
    endfunction

endpackage

// File: rtl/nios_mul_if.sv
// Operation/result bundle between the execute stage and the multiplier.
interface nios_mul_if
    import nios_mul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) ();

    logic              en;
    logic              flush;
    logic              in_valid;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_lo;
    logic [DATA_W-1:0] out_hi;
    logic              busy;

    modport master (
        output en, flush, in_valid, in_op, in_src1, in_src2, in_tag,
        input  out_valid, out_tag, out_lo, out_hi, busy
    );

    modport slave (
        input  en, flush, in_valid, in_op, in_src1, in_src2, in_tag,
        output out_valid, out_tag, out_lo, out_hi, busy
    );

endinterface

// File: rtl/nios_mul_slice.sv
// One registered unsigned SLICE_W x SLICE_W multiply; sized to map onto a single DSP block.
module nios_mul_slice
#(
    parameter int SLICE_W = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic [SLICE_W-1:0]   a,
    input  logic [SLICE_W-1:0]   b,
    output logic [2*SLICE_W-1:0] p
);

    // Partial product register: synchronous clear wins, otherwise capture on enable.
    always_ff @(posedge clk) begin
        if (clr) begin
            p <= '0;
        end else if (en) begin
            p <= {{SLICE_W{1'b0}}, a} * {{SLICE_W{1'b0}}, b};
        end
    end

endmodule

// File: rtl/nios_mul_unit.sv
// Pipelined DATA_W x DATA_W multiplier producing the full 2*DATA_W product.
// Signed operands are handled by multiplying the raw bit patterns unsigned and
// subtracting src<<DATA_W for each negative signed operand; the 2^(2*DATA_W)
// cross term vanishes because every sum is truncated to 2*DATA_W bits.
module nios_mul_unit
    import nios_mul_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SLICE_W     = 16,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input logic       clk,
    input logic       reset_n,
    nios_mul_if.slave bus
);

    localparam int N_SL = DATA_W / SLICE_W;
    localparam int N_PP = N_SL * N_SL;
    localparam int W2   = 2 * DATA_W;

    mul_op_e in_op_e;
    logic    a_neg;
    logic    b_neg;

    logic [2*SLICE_W-1:0] pp [N_PP];

    logic              s1_valid;
    logic [TAG_W-1:0]  s1_tag;
    mul_op_e           s1_op;
    logic [W2-1:0]     s1_corr_a;
    logic [W2-1:0]     s1_corr_b;

    logic [W2-1:0]     pp_sum;
    logic [W2-1:0]     prod;

    logic              s2_valid;
    logic [TAG_W-1:0]  s2_tag;
    logic [W2-1:0]     s2_prod;

    logic              s3_busy;

    assign in_op_e = mul_op_e'(bus.in_op);
    assign a_neg   = is_a_signed(in_op_e) && bus.in_src1[DATA_W-1];
    assign b_neg   = is_b_signed(in_op_e) && bus.in_src2[DATA_W-1];

    // Stage 1 partial products: slice i of src1 times slice j of src2.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N_SL; gi++) begin : g_row
            for (gj = 0; gj < N_SL; gj++) begin : g_col
                nios_mul_slice #(
                    .SLICE_W (SLICE_W)
                ) u_slice (
                    .clk (clk),
                    .clr (!reset_n),
                    .en  (bus.en),
                    .a   (bus.in_src1[gi*SLICE_W +: SLICE_W]),
                    .b   (bus.in_src2[gj*SLICE_W +: SLICE_W]),
                    .p   (pp[gi*N_SL + gj])
                );
            end
        end
    endgenerate

    // Stage 1 control: valid/tag/op and the two signedness correction terms.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_tag    <= '0;
            s1_op     <= MUL;
            s1_corr_a <= '0;
            s1_corr_b <= '0;
        end else begin
            if (bus.flush) begin
                s1_valid <= 1'b0;
            end else if (bus.en) begin
                s1_valid <= bus.in_valid;
            end
            if (bus.en) begin
                s1_tag    <= bus.in_tag;
                s1_op     <= in_op_e;
                s1_corr_a <= a_neg ? {bus.in_src2, {DATA_W{1'b0}}} : '0;
                s1_corr_b <= b_neg ? {bus.in_src1, {DATA_W{1'b0}}} : '0;
            end
        end
    end

    // Stage 2 adder tree: shift and sum the partial products, then apply corrections.
    // The registered op re-gates the corrections so a plain mul never sees one.
    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < N_SL; i++) begin
            for (int j = 0; j < N_SL; j++) begin
                pp_sum = pp_sum + (W2'(pp[i*N_SL + j]) << ((i + j) * SLICE_W));
            end
        end
        prod = pp_sum
             - (is_a_signed(s1_op) ? s1_corr_a : '0)
             - (is_b_signed(s1_op) ? s1_corr_b : '0);
    end

    // Stage 2 result register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_tag   <= '0;
            s2_prod  <= '0;
        end else begin
            if (bus.flush) begin
                s2_valid <= 1'b0;
            end else if (bus.en) begin
                s2_valid <= s1_valid;
            end
            if (bus.en) begin
                s2_tag  <= s2_tag_next();
                s2_prod <= prod;
            end
        end
    end

    function automatic logic [TAG_W-1:0] s2_tag_next();
        return s1_tag;
    endfunction

    generate
        if (PIPE_STAGES == PIPE_STAGES_MAX) begin : g_out_reg
            logic              s3_valid;
            logic [TAG_W-1:0]  s3_tag;
            logic [W2-1:0]     s3_prod;

            // Optional stage 3: plain output register for timing closure.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    s3_valid <= 1'b0;
                    s3_tag   <= '0;
                    s3_prod  <= '0;
                end else begin
                    if (bus.flush) begin
                        s3_valid <= 1'b0;
                    end else if (bus.en) begin
                        s3_valid <= s2_valid;
                    end
                    if (bus.en) begin
                        s3_tag  <= s2_tag;
                        s3_prod <= s2_prod;
                    end
                end
            end

            assign bus.out_valid = s3_valid;
            assign bus.out_tag   = s3_tag;
            assign bus.out_lo    = s3_prod[DATA_W-1:0];
            assign bus.out_hi    = s3_prod[W2-1:DATA_W];
            assign s3_busy       = s3_valid;
        end else begin : g_no_out_reg
            assign bus.out_valid = s2_valid;
            assign bus.out_tag   = s2_tag;
            assign bus.out_lo    = s2_prod[DATA_W-1:0];
            assign bus.out_hi    = s2_prod[W2-1:DATA_W];
            assign s3_busy       = 1'b0;
        end
    endgenerate

    assign bus.busy = s1_valid | s2_valid | s3_busy;

endmodule

// File: tb/tb_nios_mul_unit.sv
// Directed self-checking bench for nios_mul_unit: default 32-bit/2-stage
// instance plus a 64-bit/3-stage instance sharing clock and reset.
module tb_nios_mul_unit;
    import nios_mul_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    mul_op_e     t_op  [8];
    logic [31:0] t_a   [8];
    logic [31:0] t_b   [8];
    logic [63:0] t_exp [8];

    nios_mul_if #(.DATA_W(32), .TAG_W(5)) bus_a ();
    nios_mul_if #(.DATA_W(64), .TAG_W(5)) bus_b ();

    nios_mul_unit #(
        .DATA_W      (32),
        .SLICE_W     (16),
        .PIPE_STAGES (2),
        .TAG_W       (5)
    ) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    nios_mul_unit #(
        .DATA_W      (64),
        .SLICE_W     (16),
        .PIPE_STAGES (3),
        .TAG_W       (5)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] refMul(input mul_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {32'h0, a};
        eb = {32'h0, b};
        if (op == MULXSS || op == MULXSU) ea = {{32{a[31]}}, a};
        if (op == MULXSS) eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input mul_op_e op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag);
        bus_a.in_valid = valid;
        bus_a.in_op    = op;
        bus_a.in_src1  = a;
        bus_a.in_src2  = b;
        bus_a.in_tag   = tag;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Issue one op on the 32-bit instance and check it appears exactly two edges later.
    task automatic runOp(input string name, input mul_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        applyStimulus(1'b1, op, a, b, tag);
        tick();
        applyStimulus(1'b0, MUL, 32'h0, 32'h0, 5'd0);
        checkOutput({name, "_early"}, 128'(bus_a.out_valid), 128'(1'b0));
        tick();
        checkOutput({name, "_valid"}, 128'(bus_a.out_valid), 128'(1'b1));
        checkOutput({name, "_tag"},   128'(bus_a.out_tag),   128'(tag));
        checkOutput({name, "_hi"},    128'(bus_a.out_hi),    128'(exp_hi));
        checkOutput({name, "_lo"},    128'(bus_a.out_lo),    128'(exp_lo));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus_a.en = 1'b1;
        bus_a.flush = 1'b0;
        applyStimulus(1'b0, MUL, 32'h0, 32'h0, 5'd0);
        bus_b.en = 1'b1;
        bus_b.flush = 1'b0;
        bus_b.in_valid = 1'b0;
        bus_b.in_op = MUL;
        bus_b.in_src1 = '0;
        bus_b.in_src2 = '0;
        bus_b.in_tag = '0;

        // Reset state.
        tick();
        tick();
        checkOutput("rst_valid", 128'(bus_a.out_valid), 128'(1'b0));
        checkOutput("rst_busy",  128'(bus_a.busy),      128'(1'b0));
        checkOutput("rst_lo",    128'(bus_a.out_lo),    128'(0));
        checkOutput("rst_hi",    128'(bus_a.out_hi),    128'(0));
        checkOutput("rst_tag",   128'(bus_a.out_tag),   128'(0));
        checkOutput("rst_b_valid", 128'(bus_b.out_valid), 128'(1'b0));
        checkOutput("rst_b_prod",  {bus_b.out_hi, bus_b.out_lo}, 128'(0));
        reset_n = 1'b1;
        tick();

        // Directed ops.
        runOp("xuu_ones", MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, 32'h00000001);
        runOp("xss_ones", MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000, 32'h00000001);
        runOp("xsu_ones", MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 32'h00000001);
        runOp("mul_low",  MUL,    32'h00012345, 32'h00010000, 5'd5, 32'h00000001, 32'h23450000);
        runOp("xss_minmin", MULXSS, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 32'h00000000);
        runOp("xss_minone", MULXSS, 32'h80000000, 32'h00000001, 5'd7, 32'hFFFFFFFF, 32'h80000000);

        // Stall: op captured, then en low for 4 edges with a junk op presented.
        applyStimulus(1'b1, MULXUU, 32'd7, 32'd9, 5'd3);
        tick();
        bus_a.en = 1'b0;
        applyStimulus(1'b1, MUL, 32'd5, 32'd5, 5'd20);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("stall_quiet", 128'(bus_a.out_valid), 128'(1'b0));
            checkOutput("stall_busy",  128'(bus_a.busy),      128'(1'b1));
        end
        bus_a.en = 1'b1;
        applyStimulus(1'b0, MUL, 32'h0, 32'h0, 5'd0);
        tick();
        checkOutput("stall_valid", 128'(bus_a.out_valid), 128'(1'b1));
        checkOutput("stall_lo",    128'(bus_a.out_lo),    128'(63));
        checkOutput("stall_hi",    128'(bus_a.out_hi),    128'(0));
        checkOutput("stall_tag",   128'(bus_a.out_tag),   128'(3));
        bus_a.en = 1'b0;
        applyStimulus(1'b1, MULXSS, 32'd11, 32'd13, 5'd21);
        tick();
        tick();
        checkOutput("hold_valid", 128'(bus_a.out_valid), 128'(1'b1));
        checkOutput("hold_lo",    128'(bus_a.out_lo),    128'(63));
        checkOutput("hold_tag",   128'(bus_a.out_tag),   128'(3));
        bus_a.en = 1'b1;
        applyStimulus(1'b0, MUL, 32'h0, 32'h0, 5'd0);
        tick();
        checkOutput("stall_no_junk", 128'(bus_a.out_valid), 128'(1'b0));
        tick();
        checkOutput("stall_no_junk2", 128'(bus_a.out_valid), 128'(1'b0));

        // Throughput: 8 back-to-back ops with a reference model.
        for (int k = 0; k < 8; k++) begin
            t_op[k]  = mul_op_e'(2'($urandom_range(0, 3)));
            t_a[k]   = $urandom();
            t_b[k]   = $urandom();
            t_exp[k] = refMul(t_op[k], t_a[k], t_b[k]);
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, t_op[k], t_a[k], t_b[k], 5'(k));
            tick();
            if (k >= 1) begin
                checkOutput("tput_valid", 128'(bus_a.out_valid), 128'(1'b1));
                checkOutput("tput_tag",   128'(bus_a.out_tag),   128'(k - 1));
                checkOutput("tput_prod",  128'({bus_a.out_hi, bus_a.out_lo}), 128'(t_exp[k-1]));
            end
        end
        applyStimulus(1'b0, MUL, 32'h0, 32'h0, 5'd0);
        tick();
        checkOutput("tput_valid", 128'(bus_a.out_valid), 128'(1'b1));
        checkOutput("tput_tag",   128'(bus_a.out_tag),   128'(7));
        checkOutput("tput_prod",  128'({bus_a.out_hi, bus_a.out_lo}), 128'(t_exp[7]));
        tick();
        checkOutput("tput_end", 128'(bus_a.out_valid), 128'(1'b0));

        // Flush with two ops in flight and a third presented on the flush edge.
        applyStimulus(1'b1, MULXUU, 32'd2, 32'd3, 5'd10);
        tick();
        applyStimulus(1'b1, MULXUU, 32'd4, 32'd5, 5'd11);
        tick();
        checkOutput("pre_flush_busy", 128'(bus_a.busy), 128'(1'b1));
        checkOutput("pre_flush_tag",  128'(bus_a.out_tag), 128'(10));
        applyStimulus(1'b1, MULXUU, 32'd6, 32'd7, 5'd12);
        bus_a.flush = 1'b1;
        tick();
        bus_a.flush = 1'b0;
        applyStimulus(1'b0, MUL, 32'h0, 32'h0, 5'd0);
        checkOutput("flush_busy",  128'(bus_a.busy),      128'(1'b0));
        checkOutput("flush_valid", 128'(bus_a.out_valid), 128'(1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("flush_none", 128'(bus_a.out_valid), 128'(1'b0));
        end

        // Flush overrides a stall.
        applyStimulus(1'b1, MULXUU, 32'd8, 32'd8, 5'd15);
        tick();
        applyStimulus(1'b0, MUL, 32'h0, 32'h0, 5'd0);
        bus_a.en = 1'b0;
        bus_a.flush = 1'b1;
        tick();
        checkOutput("flush_stall_busy", 128'(bus_a.busy), 128'(1'b0));
        bus_a.en = 1'b1;
        bus_a.flush = 1'b0;
        tick();
        tick();
        checkOutput("flush_stall_none", 128'(bus_a.out_valid), 128'(1'b0));

        // Reset mid-flight.
        applyStimulus(1'b1, MULXUU, 32'hFFFFFFFF, 32'd2, 5'd13);
        tick();
        applyStimulus(1'b1, MULXUU, 32'hFFFFFFFF, 32'd3, 5'd14);
        tick();
        checkOutput("pre_rst_lo", 128'(bus_a.out_lo), 128'(32'hFFFFFFFE));
        applyStimulus(1'b1, MULXUU, 32'hFFFFFFFF, 32'd4, 5'd16);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        applyStimulus(1'b0, MUL, 32'h0, 32'h0, 5'd0);
        checkOutput("midrst_valid", 128'(bus_a.out_valid), 128'(1'b0));
        checkOutput("midrst_busy",  128'(bus_a.busy),      128'(1'b0));
        checkOutput("midrst_lo",    128'(bus_a.out_lo),    128'(0));
        checkOutput("midrst_hi",    128'(bus_a.out_hi),    128'(0));
        checkOutput("midrst_tag",   128'(bus_a.out_tag),   128'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("midrst_none", 128'(bus_a.out_valid), 128'(1'b0));
        end

        // 64-bit, three-stage instance.
        bus_b.in_valid = 1'b1;
        bus_b.in_op    = MULXUU;
        bus_b.in_src1  = 64'hFFFFFFFFFFFFFFFF;
        bus_b.in_src2  = 64'hFFFFFFFFFFFFFFFF;
        bus_b.in_tag   = 5'd21;
        tick();
        bus_b.in_valid = 1'b0;
        tick();
        checkOutput("w64_early", 128'(bus_b.out_valid), 128'(1'b0));
        tick();
        checkOutput("w64_valid", 128'(bus_b.out_valid), 128'(1'b1));
        checkOutput("w64_tag",   128'(bus_b.out_tag),   128'(21));
        checkOutput("w64_hi",    128'(bus_b.out_hi),    128'(64'hFFFFFFFFFFFFFFFE));
        checkOutput("w64_lo",    128'(bus_b.out_lo),    128'(64'h1));

        bus_b.in_valid = 1'b1;
        bus_b.in_op    = MULXSS;
        bus_b.in_src1  = 64'hFFFFFFFFFFFFFFFD;
        bus_b.in_src2  = 64'h0000000000000005;
        bus_b.in_tag   = 5'd22;
        tick();
        bus_b.in_valid = 1'b0;
        tick();
        tick();
        checkOutput("w64_xss_hi", 128'(bus_b.out_hi), 128'(64'hFFFFFFFFFFFFFFFF));
        checkOutput("w64_xss_lo", 128'(bus_b.out_lo), 128'(64'hFFFFFFFFFFFFFFF1));
        tick();
        checkOutput("w64_end", 128'(bus_b.out_valid), 128'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_mul_unit.md
Name: nios_mul_unit

Overview:
- Parametrised, pipelined integer multiplier for the Nios core execute/memory path.
- Successor to the fixed 16x16 three-cell multiplier. It produces the full 2*DATA_W product, both low and high words.
- Supports the four Nios multiply ops: mul, mulxss, mulxsu, mulxuu.
- Adds valid/tag tracking, a stall enable and a pipeline flush.

Parameters:
- DATA_W, 32, operand width; must be a multiple of SLICE_W.
- SLICE_W, 16, width of one partial-product slice (the DSP-native width).
- PIPE_STAGES, 2, result latency in cycles; legal values 2 or 3. 3 adds an output register.
- TAG_W, 5, width of the destination tag carried alongside each operation.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  pipeline advance enable. 0 freezes every stage.
- flush  in  1  kill all in-flight ops; synchronous, overrides en.
- in_valid  in  1  operation present on the in_* ports.
- in_op  in  2  00=mul, 01=mulxss, 10=mulxsu, 11=mulxuu.
- in_src1  in  DATA_W  operand A; signed for xss/xsu.
- in_src2  in  DATA_W  operand B; signed for xss only.
- in_tag  in  TAG_W  destination tag, returned unchanged.
- out_valid  out  1  result valid.
- out_tag  out  TAG_W  tag of the result.
- out_lo  out  DATA_W  product bits [DATA_W-1:0].
- out_hi  out  DATA_W  product bits [2*DATA_W-1:DATA_W].
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All stage valids, out_valid and busy go to 0.
  - All data and tag registers, including out_lo, out_hi and out_tag, go to 0.
  - Reset applies regardless of en or flush and aborts in-flight ops; nothing emerges afterwards.
- Stage 1 (captured when en=1):
  - Registers (DATA_W/SLICE_W)^2 unsigned SLICE_W x SLICE_W partial products of the raw operands.
  - Registers two 2*DATA_W correction terms:
    - corrA = src2<<DATA_W when A is treated as signed and src1[msb]=1, else 0.
    - corrB = src1<<DATA_W when B is treated as signed and src2[msb]=1, else 0.
  - Registers valid, tag and op.
- Stage 2: sums the shifted partial products, then subtracts corrA and corrB, modulo 2^(2*DATA_W). The result is registered.
- Stage 3 (only when PIPE_STAGES=3): a plain output register.
- Signedness rules:
  - mul: out_lo holds the low word. Signedness does not matter for the low word; it is computed as unsigned. out_hi holds the unsigned high word.
  - mulxss: signed x signed.
  - mulxsu: signed src1 x unsigned src2.
  - mulxuu: unsigned x unsigned.
- Latency and throughput:
  - With en held at 1, the result appears PIPE_STAGES edges after the in_valid edge.
  - Throughput is one op per cycle; no bubbles between back-to-back ops.
- Stall (en=0):
  - All registers hold, including out_valid, out_lo, out_hi and out_tag.
  - in_* inputs are ignored and not captured.
  - A result stays presented until en returns to 1.
- Flush:
  - On an edge with flush=1, every stage valid clears, including out_valid, even if en=0.
  - An in_valid op presented in the same cycle is discarded.
  - Data registers may keep stale values; out_lo, out_hi and out_tag are don't-care while out_valid=0.
- in_valid=0 with en=1: a bubble (valid=0) propagates. Data registers may update or hold; they are don't-care.
- Width rule:
  - All internal sums are exactly 2*DATA_W bits; overflow beyond 2*DATA_W is discarded.
  - No saturation and no exceptions.

Decomposition:
- Package nios_mul_pkg holds:
  - the op enum (MUL, MULXSS, MULXSU, MULXUU);
  - the legal PIPE_STAGES constants;
  - a function is_a_signed(op) and a function is_b_signed(op).
- Sub-module nios_mul_slice: a registered SLICE_W x SLICE_W unsigned multiply with enable and synchronous clear, mapping to one DSP block.
  - The top instantiates (DATA_W/SLICE_W)^2 of these via generate.
  - Correction terms, adder tree and valid/tag pipeline live in the top.

Test Plan:
- Reset and directed ops, default params, en=1. Reset, then the four op=11/01/10/00 cases below:
  - mulxuu 0xFFFFFFFF x 0xFFFFFFFF -> 2 cycles later out_valid=1, hi=0xFFFFFFFE, lo=0x00000001.
  - mulxss 0xFFFFFFFF x 0xFFFFFFFF -> hi=0x00000000, lo=0x00000001.
  - mulxsu same operands -> hi=0xFFFFFFFF, lo=0x00000001.
  - mul 0x00012345 x 0x00010000 -> lo=0x23450000.
- Signed extreme: mulxss 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0; mulxss 0x80000000 x 0x00000001 -> hi=0xFFFFFFFF, lo=0x80000000.
- Stall: issue tag 3 (7x9), drop en for 4 cycles after 1 edge -> no output during the stall; out_valid rises 1 edge after en returns with lo=63, tag=3, then holds while en=0.
- Throughput: 8 back-to-back random ops (tags 0..7) -> 8 consecutive out_valid cycles, tags in order, each matching a 64-bit reference model.
- Flush and reset:
  - With 2 ops in flight, assert flush with a new in_valid -> next cycle busy=0, out_valid=0, and none of the 3 ops ever appear.
  - Repeat with reset_n=0 mid-flight -> all outputs zero, nothing emerges afterwards.
- PIPE_STAGES=3, DATA_W=64, SLICE_W=16: mulxuu (2^64-1)^2 -> 3 cycles later hi=0xFFFFFFFFFFFFFFFE, lo=1.
